// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: each channel shows a
// magnitude digit and a sign digit, with value updates deferred to frame boundaries.
module seg_scan_ctrl #(
  parameter int NCH = 4,
  parameter int DIV = 1000,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [3:0]           wr_data,
  input  logic                 blank_en,
  output logic [6:0]           seg,
  output logic [2*NCH-1:0]     an,
  output logic                 frame_tick
);

  localparam int NSLOT = 2 * NCH;
  localparam int PW    = $clog2(DIV);
  localparam int SW    = $clog2(NSLOT);

  logic [PW-1:0]    r_presc;
  logic [SW-1:0]    r_slot;
  logic [3:0]       r_val [NCH];
  logic             r_buf_full;
  logic [CHW-1:0]   r_buf_ch;
  logic [3:0]       r_buf_data;
  logic [6:0]       r_seg;
  logic [NSLOT-1:0] r_an;
  logic             r_frame_tick;

  logic             w_tick;
  logic             w_frame_end;
  logic             w_accept;
  logic             w_commit;
  logic [NCH-1:0]   w_ch_sel;
  logic [CHW-1:0]   w_ch;
  logic [3:0]       w_val;
  logic [3:0]       w_mag;
  logic [6:0]       w_mag_seg;
  logic [6:0]       w_dig_seg;
  logic [NSLOT-1:0] w_an_dec;

  assign w_tick      = (r_presc == PW'(DIV - 1));
  assign w_frame_end = w_tick && (r_slot == SW'(NSLOT - 1));
  assign w_accept    = wr_valid && !r_buf_full;
  assign w_commit    = w_frame_end && r_buf_full;
  assign wr_ready    = !r_buf_full;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch_sel
    assign w_ch_sel[gi] = (r_buf_ch == CHW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_slot  <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_slot  <= (r_slot == SW'(NSLOT - 1)) ? '0 : r_slot + SW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Buffer can only be refilled once empty, so commit and accept never coincide;
  // an out-of-range channel matches no w_ch_sel bit and is dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_ch   <= '0;
      r_buf_data <= '0;
      for (int k = 0; k < NCH; k++) r_val[k] <= '0;
    end else begin
      if (w_commit) begin
        r_buf_full <= 1'b0;
        for (int k = 0; k < NCH; k++) begin
          if (w_ch_sel[k]) r_val[k] <= r_buf_data;
        end
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_ch   <= wr_ch;
        r_buf_data <= wr_data;
      end
    end
  end

  always_comb begin
    w_ch      = CHW'(r_slot >> 1);
    w_val     = r_val[w_ch];
    w_mag     = w_val[3] ? (4'd0 - w_val) : w_val;
    w_mag_seg = 7'b1111111;
    case (w_mag)
      4'd0:    w_mag_seg = 7'b0000001;
      4'd1:    w_mag_seg = 7'b1001111;
      4'd2:    w_mag_seg = 7'b0010010;
      4'd3:    w_mag_seg = 7'b0000110;
      4'd4:    w_mag_seg = 7'b1001100;
      4'd5:    w_mag_seg = 7'b0100100;
      4'd6:    w_mag_seg = 7'b0100000;
      4'd7:    w_mag_seg = 7'b0001111;
      4'd8:    w_mag_seg = 7'b0000000;
      default: w_mag_seg = 7'b1111111;
    endcase
    w_dig_seg = r_slot[0] ? (w_val[3] ? 7'b1111110 : 7'b1111111) : w_mag_seg;
    w_an_dec  = ~(NSLOT'(1) << r_slot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= 7'b1111111;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (blank_en) begin
        r_seg <= 7'b1111111;
        r_an  <= '1;
      end else begin
        r_seg <= w_dig_seg;
        r_an  <= w_an_dec;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule
